// File: rtl/aemb2_icf_ctrl.sv
// I-cache refill controller: stalls fetch on a miss and refills over Wishbone (AEMB2_ICF_WHOLE_LINE_EN: whole wrapping line, else one word).
// Latency: stall = 2 + beats + bus wait states; a slow bus (iwb_ack_i low) simply holds every output.
module aemb2_icf_ctrl #(
  parameter int AEMB_IWB = 32,
  parameter int AEMB_IDX = 6
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic [AEMB_IWB-3:0] fch_adr,
  input  logic                fch_req,
  input  logic                ich_hit,
  output logic [AEMB_IWB-3:0] ich_adr,
  output logic                fch_stall,
  output logic [AEMB_IWB-3:0] iwb_adr_o,
  output logic                iwb_stb_o,
  output logic                iwb_cyc_o,
  output logic                iwb_wre_o,
  output logic [3:0]          iwb_sel_o,
  input  logic                iwb_ack_i
);

  localparam int AW = AEMB_IWB - 2;

  if (AEMB_IDX < 3 || AEMB_IDX > 6) begin : gBadIdx
    $error("AEMB_IDX must give a line of 2 to 16 words");
  end

  typedef enum logic [1:0] {IDLE, FILL, SYNC} state_t;

  state_t        state, stateNxt;
  logic [AW-1:0] misAdr;
  logic          miss;
  logic          lastBeat;

  assign miss = fch_req & ~ich_hit;

`ifdef AEMB2_ICF_WHOLE_LINE_EN
  localparam int LNE = AEMB_IDX - 2;

  logic [LNE-1:0] cnt;
  logic [LNE-1:0] nxtIdx;

  // Next word wraps inside the line, starting from the critical word.
  assign nxtIdx   = misAdr[LNE-1:0] + cnt + LNE'(1);
  assign lastBeat = (cnt == '1);

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == FILL && iwb_ack_i) begin
      cnt <= cnt + LNE'(1);
    end
  end
`else
  assign lastBeat = 1'b1;
`endif

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    ich_adr   = fch_adr;
    fch_stall = 1'b1;
    case (state)
      IDLE: begin
        fch_stall = miss;
        if (miss) stateNxt = FILL;
      end
      FILL: begin
        ich_adr = iwb_adr_o;
        if (iwb_ack_i && lastBeat) stateNxt = SYNC;
      end
      SYNC: begin
        // Gives the synchronous tag/data RAMs a cycle to present the refilled word.
        ich_adr  = misAdr;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      misAdr    <= '0;
      iwb_adr_o <= '0;
      iwb_stb_o <= 1'b0;
      iwb_cyc_o <= 1'b0;
    end else if (state == IDLE && miss) begin
      misAdr    <= fch_adr;
      iwb_adr_o <= fch_adr;
      iwb_stb_o <= 1'b1;
      iwb_cyc_o <= 1'b1;
    end else if (state == FILL && iwb_ack_i) begin
      if (lastBeat) begin
        iwb_stb_o <= 1'b0;
        iwb_cyc_o <= 1'b0;
      end
`ifdef AEMB2_ICF_WHOLE_LINE_EN
      else begin
        iwb_adr_o <= {misAdr[AW-1:LNE], nxtIdx};
      end
`endif
    end
  end

  assign iwb_sel_o = iwb_stb_o ? 4'hF : 4'h0;
  assign iwb_wre_o = 1'b0;

endmodule

// File: tb/tb_aemb2_icf_ctrl.sv
// Bench for aemb2_icf_ctrl: random fetches against an ideal cache model, beats checked by a scoreboard.
module tb_aemb2_icf_ctrl;

  localparam int LINE = 16;
`ifdef AEMB2_ICF_WHOLE_LINE_EN
  localparam int BEATS = LINE;
`else
  localparam int BEATS = 1;
`endif
  localparam int RST_TGT = (BEATS > 4) ? 4 : 0;

  logic        gclk = 1'b0;
  logic        grst;
  logic [29:0] fch_adr;
  logic        fch_req;
  logic        ich_hit;
  logic [29:0] ich_adr;
  logic        fch_stall;
  logic [29:0] iwb_adr_o;
  logic        iwb_stb_o;
  logic        iwb_cyc_o;
  logic        iwb_wre_o;
  logic [3:0]  iwb_sel_o;
  logic        iwb_ack_i;

  always #5 gclk = ~gclk;

  aemb2_icf_ctrl #(.AEMB_IWB(32), .AEMB_IDX(6)) dut (
    .gclk(gclk), .grst(grst),
    .fch_adr(fch_adr), .fch_req(fch_req), .ich_hit(ich_hit),
    .ich_adr(ich_adr), .fch_stall(fch_stall),
    .iwb_adr_o(iwb_adr_o), .iwb_stb_o(iwb_stb_o), .iwb_cyc_o(iwb_cyc_o),
    .iwb_wre_o(iwb_wre_o), .iwb_sel_o(iwb_sel_o), .iwb_ack_i(iwb_ack_i)
  );

  int          errors = 0;
  int          checks = 0;
  logic [29:0] expQ[$];
  bit          cached[logic [29:0]];
  int          waitMode = 0;
  int          waitLeft = 0;
  int          beatNo = 0;
  int          totalWaits = 0;
  int          beatsSeen = 0;
  logic        stbN = 1'b0;
  logic        ackN = 1'b0;
  logic [29:0] monE;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected refill order: critical word first, wrapping inside its line.
  task automatic pushLine(input logic [29:0] a);
    int base = int'(a) & ~(LINE - 1);
    int off  = int'(a) % LINE;
    for (int k = 0; k < BEATS; k++) expQ.push_back(30'(base + (off + k) % LINE));
  endtask

  // Wishbone slave: per-beat wait states, ack noise while no strobe, ack held high in reset.
  initial begin
    iwb_ack_i = 1'b0;
    forever begin
      @(posedge gclk); #1;
      if (!grst) begin
        iwb_ack_i = 1'b1;
      end else if (iwb_stb_o) begin
        if (!stbN) beatNo = 0;
        if (!stbN || ackN) begin
          if (waitMode == 1) waitLeft = int'($urandom_range(0, 2));
          else if (waitMode == 2 && beatNo % 4 == 3) waitLeft = 2;
          else waitLeft = 0;
          totalWaits += waitLeft;
          beatNo++;
        end
        if (waitLeft == 0) iwb_ack_i = 1'b1;
        else begin
          iwb_ack_i = 1'b0;
          waitLeft--;
        end
      end else begin
        iwb_ack_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Scoreboard monitor: every accepted beat is popped and compared.
  always @(negedge gclk) begin
    if (grst && iwb_stb_o && iwb_ack_i) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none", iwb_adr_o);
      end else begin
        monE = expQ.pop_front();
        check("beat_adr", iwb_adr_o, monE);
        check("beat_ich_adr", ich_adr, monE);
        check("beat_sel", iwb_sel_o, 4'hF);
        check("beat_cyc_wre", {iwb_cyc_o, iwb_wre_o}, 2'b10);
      end
      cached[iwb_adr_o] = 1'b1;
      beatsSeen++;
    end
    stbN = iwb_stb_o;
    ackN = iwb_ack_i;
  end

  task automatic doAccess(input logic [29:0] a, input bit req, input bit forceMiss);
    bit miss;
    bit done = 1'b0;
    int stallCyc = 1;
    int syncCyc = 0;
    @(posedge gclk); #1;
    fch_adr    = a;
    fch_req    = req;
    ich_hit    = forceMiss ? 1'b0 : cached.exists(a);
    miss       = req && !ich_hit;
    totalWaits = 0;
    if (miss) pushLine(a);
    @(negedge gclk);
    check("stall_detect", fch_stall, miss);
    check("ich_adr_idle", ich_adr, a);
    if (!miss) return;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge gclk); #1;
      if (iwb_cyc_o) begin
        fch_adr = 30'($urandom);
        fch_req = 1'($urandom_range(0, 1));
        ich_hit = 1'($urandom_range(0, 1));
      end else begin
        fch_adr = a;
        fch_req = 1'b1;
        ich_hit = cached.exists(a);
      end
      @(negedge gclk);
      if (fch_stall) begin
        stallCyc++;
        if (!iwb_cyc_o) begin
          syncCyc++;
          check("sync_ich_adr", ich_adr, a);
        end
      end else begin
        done = 1'b1;
      end
    end
    check("stall_released", done, 1);
    check("stall_len", stallCyc, 2 + BEATS + totalWaits);
    check("sync_cycles", syncCyc, 1);
    check("beats_left", expQ.size(), 0);
    check("idle_bus", {iwb_cyc_o, iwb_stb_o, iwb_sel_o}, 0);
  endtask

  task automatic resetMidFill(input logic [29:0] a);
    bit found = 1'b0;
    waitMode  = 0;
    beatsSeen = 0;
    @(posedge gclk); #1;
    fch_adr = a;
    fch_req = 1'b1;
    ich_hit = 1'b0;
    pushLine(a);
    for (int n = 0; n < 100 && !found; n++) begin
      @(posedge gclk); #2;
      if (iwb_stb_o && beatsSeen == RST_TGT) found = 1'b1;
      else if (iwb_cyc_o) fch_adr = 30'($urandom);
    end
    check("rst_beat_reached", found, 1);
    grst    = 1'b0;
    fch_req = 1'b0;
    #1;
    check("rst_async_bus", {iwb_cyc_o, iwb_stb_o, iwb_sel_o}, 0);
    check("rst_async_stall", fch_stall, 0);
    expQ.delete();
    @(posedge gclk); #1;
    grst = 1'b1;
  endtask

  initial begin
    grst    = 1'b0;
    fch_adr = '0;
    fch_req = 1'b0;
    ich_hit = 1'b0;
    repeat (3) @(negedge gclk);
    check("rst_bus", {iwb_cyc_o, iwb_stb_o, iwb_sel_o}, 0);
    check("rst_adr", iwb_adr_o, 0);
    check("rst_stall", fch_stall, 0);
    check("rst_wre", iwb_wre_o, 0);
    @(posedge gclk); #1;
    grst = 1'b1;

    cached[30'h100] = 1'b1;
    doAccess(30'h100, 1'b1, 1'b0);
    @(negedge gclk);
    check("hit_no_cycle", iwb_cyc_o, 0);

    waitMode = 0;
    doAccess(30'h40E, 1'b1, 1'b0);      // byte 0x1038
    waitMode = 2;
    doAccess(30'hC02, 1'b1, 1'b0);      // byte 0x3008
    resetMidFill(30'h40E);
    waitMode = 0;
    doAccess(30'h40E, 1'b1, 1'b1);
    doAccess(30'h801, 1'b1, 1'b0);      // byte 0x2004

    for (int i = 0; i < 40; i++) begin
      waitMode = int'($urandom_range(0, 2));
      doAccess(30'(32'h1000 + $urandom_range(0, 127)), ($urandom_range(0, 4) != 0), 1'b0);
    end

    @(posedge gclk); #1;
    fch_req = 1'b0;
    repeat (2) @(negedge gclk);
    check("final_queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aemb2_icf_ctrl.md
Name: aemb2_icf_ctrl

Overview:
- Instruction-cache refill controller for the AEMB2 fetch path.
- Detects a fetch miss from the single-cycle instruction cache and stalls the pipeline.
- Runs a Wishbone read cycle that refills the missed line, critical word first, wrapping within the line. Each acked word is written into the cache.
- Drives the cache address: fill address during a refill, pipeline fetch address otherwise.

Parameters:
AEMB_IWB, 32, instruction bus address width (byte address bits; word address is [AEMB_IWB-1:2])
AEMB_IDX, 6, line index boundary; line holds 2^(AEMB_IDX-2) words (max 16, min 2)

Ports:
gclk  in  1  system clock, all state on rising edge
grst  in  1  asynchronous active-low reset
fch_adr  in  AEMB_IWB-2  fetch word address from pipeline [AEMB_IWB-1:2]
fch_req  in  1  fetch request valid this cycle
ich_hit  in  1  cache hit for current ich_adr (combinational from cache)
ich_adr  out  AEMB_IWB-2  address to cache tag/data blocks
fch_stall  out  1  pipeline stall; pipeline drives iena = ~fch_stall
iwb_adr_o  out  AEMB_IWB-2  Wishbone word address
iwb_stb_o  out  1  Wishbone strobe
iwb_cyc_o  out  1  Wishbone cycle
iwb_wre_o  out  1  Wishbone write enable, constant 0
iwb_sel_o  out  4  byte selects, 4'hF while stb high, else 4'h0
iwb_ack_i  in  1  Wishbone acknowledge; also the cache write strobe

Behaviour:
- Reset (grst low, async): state IDLE, counter 0, latched address 0, iwb_stb_o/iwb_cyc_o 0, iwb_sel_o 0, iwb_adr_o 0, fch_stall 0 (until first miss).
- LNE = AEMB_IDX-2. Word index = low LNE bits of the word address. Counter width LNE.
- States: IDLE, FILL, SYNC.
- IDLE:
  - ich_adr = fch_adr.
  - fch_stall = fch_req & ~ich_hit (combinational).
  - On a clock edge with fch_req & ~ich_hit: latch mis_adr = fch_adr, cnt = 0, go to FILL.
  - iwb_ack_i is ignored in IDLE.
- FILL:
  - iwb_cyc_o = iwb_stb_o = 1, fch_stall = 1.
  - iwb_adr_o = ich_adr = {mis_adr[upper], (mis_adr[LNE-1:0] + cnt) mod 2^LNE}. Upper part is the tag+block bits, fixed.
  - Addresses are registered; they change only on the edge after an ack.
  - On each iwb_ack_i: cnt++.
  - On the ack where cnt == (2^LNE)-1: deassert cyc/stb on the next edge, go to SYNC.
  - Wait states (ack low) hold all outputs.
  - fch_adr and fch_req are ignored while in FILL.
- SYNC:
  - One cycle; ich_adr = mis_adr, fch_stall = 1, cyc/stb 0.
  - Lets the synchronous data RAM and tag RAM present the refilled word.
  - Next edge → IDLE. The miss re-evaluates as a hit and the stall drops.
- Total stall for a zero-wait-state bus: 1 (detect) + 2^LNE (FILL) + 1 (SYNC) cycles.
- Reset mid-FILL: cyc/stb drop asynchronously and the bus cycle is abandoned. Words already acked remain valid in the cache (per-word valid bits). The next miss refetches the rest.
- Back-to-back misses: IDLE evaluates the new fch_adr in the cycle after SYNC. No bubble beyond SYNC.

Optional Feature:
AEMB2_ICF_WHOLE_LINE_EN
- Defined: full-line wrapping refill as described above (2^LNE beats).
- Undefined: single-word refill. FILL issues one beat at mis_adr, and the first ack goes to SYNC. Stall = 3 cycles with a zero-wait bus. The counter is removed.

Test Plan:
- Reset: hold grst=0 with iwb_ack_i=1 → cyc/stb/sel = 0, fch_stall=0. Release; fch_req=1, ich_hit=1 at 0x100 (word) → no bus cycle, ich_adr=0x100.
- Wrap fill (macro on, IDX=6): miss at byte 0x1038 → iwb_adr_o byte sequence 0x1038, 0x103C, 0x1000 … 0x1034. 16 acks, then SYNC with ich_adr=0x1038/4, then stall drops.
- Wait states: insert 2 idle cycles before every 4th ack → address holds through waits, stall lasts 16+4×2+2=26 cycles.
- Pipeline noise: change fch_adr every cycle during FILL → iwb_adr_o sequence unchanged.
- Reset at the 5th beat: grst low → cyc/stb 0 in the same cycle. Re-miss on 0x1038 → fresh 16-beat fill starting at 0x1038.
- Macro off: miss at 0x2004 → exactly one beat at 0x2004, stall = 3 cycles, then IDLE.
